// File: rtl/chip_instr_ip_cache02_pkg.sv
// Shared constants for the single-cycle MIPS-subset core: opcodes, functs,
// ALU operation codes and branch/jump selectors.
package chip_instr_ip_cache02_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_AND  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_XOR  = 5'd4,
    ALU_NOR  = 5'd5,
    ALU_SLT  = 5'd6,
    ALU_SLTU = 5'd7,
    ALU_SLL  = 5'd8,
    ALU_SRL  = 5'd9,
    ALU_SRA  = 5'd10,
    ALU_LUI  = 5'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_JUMP = 2'b11
  } branch_e;

endpackage

// File: rtl/chip_instr_ip_cache02_control.sv
// Main decoder: opcode/funct to datapath control. Anything not recognised
// decodes as a NOP with every write enable low.
module chip_instr_ip_cache02_control
  import chip_instr_ip_cache02_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output logic       mem_to_reg_o,
  output logic       mem_write_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic       alu_src_b_o,
  output logic       reg_dst_o,
  output logic       extend_o,
  output logic       pc_to_reg_o,
  output logic [4:0] alu_ctrl_o,
  output logic [1:0] branch_o
);

  alu_op_e alu_op;
  branch_e br;

  always_comb begin
    mem_to_reg_o = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 1'b0;
    reg_dst_o    = 1'b0;
    extend_o     = 1'b0;
    pc_to_reg_o  = 1'b0;
    alu_op       = ALU_ADD;
    br           = BR_NONE;
    case (op_i)
      OP_RTYPE: begin
        reg_dst_o   = 1'b1;
        extend_o    = 1'b1;
        reg_write_o = 1'b1;
        case (funct_i)
          FN_ADD, FN_ADDU: alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: alu_op = ALU_SUB;
          FN_AND:          alu_op = ALU_AND;
          FN_OR:           alu_op = ALU_OR;
          FN_XOR:          alu_op = ALU_XOR;
          FN_NOR:          alu_op = ALU_NOR;
          FN_SLT:          alu_op = ALU_SLT;
          FN_SLTU:         alu_op = ALU_SLTU;
          FN_SLL: begin alu_op = ALU_SLL; alu_src_a_o = 1'b1; end
          FN_SRL: begin alu_op = ALU_SRL; alu_src_a_o = 1'b1; end
          FN_SRA: begin alu_op = ALU_SRA; alu_src_a_o = 1'b1; end
          default: begin reg_dst_o = 1'b0; extend_o = 1'b0; reg_write_o = 1'b0; end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin reg_write_o = 1'b1; alu_src_b_o = 1'b1; extend_o = 1'b1; end
      OP_SLTI: begin
        reg_write_o = 1'b1; alu_src_b_o = 1'b1; extend_o = 1'b1; alu_op = ALU_SLT;
      end
      OP_ANDI: begin reg_write_o = 1'b1; alu_src_b_o = 1'b1; alu_op = ALU_AND; end
      OP_ORI:  begin reg_write_o = 1'b1; alu_src_b_o = 1'b1; alu_op = ALU_OR;  end
      OP_XORI: begin reg_write_o = 1'b1; alu_src_b_o = 1'b1; alu_op = ALU_XOR; end
      OP_LUI:  begin reg_write_o = 1'b1; alu_src_b_o = 1'b1; alu_op = ALU_LUI; end
      OP_LW: begin
        reg_write_o = 1'b1; mem_to_reg_o = 1'b1; alu_src_b_o = 1'b1; extend_o = 1'b1;
      end
      OP_SW:  begin mem_write_o = 1'b1; alu_src_b_o = 1'b1; extend_o = 1'b1; end
      OP_BEQ: begin extend_o = 1'b1; alu_op = ALU_SUB; br = BR_BEQ; end
      OP_BNE: begin extend_o = 1'b1; alu_op = ALU_SUB; br = BR_BNE; end
      OP_J:   br = BR_JUMP;
      OP_JAL: begin br = BR_JUMP; reg_write_o = 1'b1; pc_to_reg_o = 1'b1; end
      default: ;
    endcase
  end

  assign alu_ctrl_o = alu_op;
  assign branch_o   = br;

endmodule

// File: rtl/chip_instr_ip_cache02.sv
// Single-cycle MIPS-subset CPU. Program ROM contents come from ROM_INIT
// (word i at bits [32*i +: 32]); every *Exp port is a live internal net.
module chip_instr_ip_cache02
  import chip_instr_ip_cache02_pkg::*;
#(
  parameter logic [8191:0] ROM_INIT = '0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] instrExp,
  output logic [31:0] PCExp,
  output logic [31:0] IPCExp,
  output logic [31:0] ExtendImmExp,
  output logic        MemtoRegExp,
  output logic        MemWriteExp,
  output logic        RegWriteExp,
  output logic        ALUSrcAExp,
  output logic        ALUSrcBExp,
  output logic        RegDstExp,
  output logic        ExtendExp,
  output logic        PCtoRegExp,
  output logic [4:0]  ALUControlExp,
  output logic [1:0]  BranchExp,
  output logic [4:0]  A3TempExp,
  output logic [4:0]  A3Exp,
  output logic [31:0] RD1Exp,
  output logic [31:0] RD2Exp,
  output logic [31:0] SrcAExp,
  output logic [31:0] SrcBExp,
  output logic [31:0] ALUResultExp,
  output logic [31:0] DataMemReadExp,
  output logic [31:0] WD3TempExp,
  output logic [31:0] WD3Exp,
  output logic        ZeroExp
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] regs_q [32];
  logic [31:0] dmem_q [64];

  logic [31:0] instr, ipc, ext_imm, rd1, rd2, src_a, src_b, alu_res, dmem_rd, wd3_tmp, wd3;
  logic [4:0]  rs, rt, rd, shamt, a3_tmp, a3;
  logic        mem_to_reg, mem_write, reg_write, alu_src_a, alu_src_b;
  logic        reg_dst, extend, pc_to_reg, zero;
  logic [4:0]  alu_ctrl;
  logic [1:0]  branch;

  assign instr = ROM_INIT[{pc_q[9:2], 5'd0} +: 32];
  assign ipc   = pc_q + 32'd4;
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign shamt = instr[10:6];

  chip_instr_ip_cache02_control u_control (
    .op_i         (instr[31:26]),
    .funct_i      (instr[5:0]),
    .mem_to_reg_o (mem_to_reg),
    .mem_write_o  (mem_write),
    .reg_write_o  (reg_write),
    .alu_src_a_o  (alu_src_a),
    .alu_src_b_o  (alu_src_b),
    .reg_dst_o    (reg_dst),
    .extend_o     (extend),
    .pc_to_reg_o  (pc_to_reg),
    .alu_ctrl_o   (alu_ctrl),
    .branch_o     (branch)
  );

  // r0 is cleared by reset and never written, so it reads zero without a mux
  assign rd1     = regs_q[rs];
  assign rd2     = regs_q[rt];
  assign ext_imm = extend ? {{16{instr[15]}}, instr[15:0]} : {16'd0, instr[15:0]};
  assign src_a   = alu_src_a ? {27'd0, shamt} : rd1;
  assign src_b   = alu_src_b ? ext_imm : rd2;

  always_comb begin
    alu_res = '0;
    case (alu_ctrl)
      ALU_ADD:  alu_res = src_a + src_b;
      ALU_SUB:  alu_res = src_a - src_b;
      ALU_AND:  alu_res = src_a & src_b;
      ALU_OR:   alu_res = src_a | src_b;
      ALU_XOR:  alu_res = src_a ^ src_b;
      ALU_NOR:  alu_res = ~(src_a | src_b);
      ALU_SLT:  alu_res = {31'd0, $signed(src_a) < $signed(src_b)};
      ALU_SLTU: alu_res = {31'd0, src_a < src_b};
      ALU_SLL:  alu_res = src_b << src_a[4:0];
      ALU_SRL:  alu_res = src_b >> src_a[4:0];
      ALU_SRA:  alu_res = $unsigned($signed(src_b) >>> src_a[4:0]);
      ALU_LUI:  alu_res = {src_b[15:0], 16'd0};
      default:  alu_res = '0;
    endcase
  end

  assign zero    = (alu_res == '0);
  assign dmem_rd = dmem_q[alu_res[7:2]];
  assign wd3_tmp = mem_to_reg ? dmem_rd : alu_res;
  assign wd3     = pc_to_reg ? ipc : wd3_tmp;
  assign a3_tmp  = reg_dst ? rd : rt;
  assign a3      = pc_to_reg ? 5'd31 : a3_tmp;

  always_comb begin
    pc_d = ipc;
    if ((branch == BR_BEQ && zero) || (branch == BR_BNE && !zero))
      pc_d = ipc + {ext_imm[29:0], 2'b00};
    else if (branch == BR_JUMP)
      pc_d = {ipc[31:28], instr[25:0], 2'b00};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= '0;
    else     pc_q <= pc_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (reg_write && a3 != 5'd0) begin
      regs_q[a3] <= wd3;
    end
  end

  // No reset on data memory contents; rst only gates the write strobe
  always_ff @(posedge clk) begin
    if (!rst && mem_write) dmem_q[alu_res[7:2]] <= rd2;
  end

  assign instrExp       = instr;
  assign PCExp          = pc_q;
  assign IPCExp         = ipc;
  assign ExtendImmExp   = ext_imm;
  assign MemtoRegExp    = mem_to_reg;
  assign MemWriteExp    = mem_write;
  assign RegWriteExp    = reg_write;
  assign ALUSrcAExp     = alu_src_a;
  assign ALUSrcBExp     = alu_src_b;
  assign RegDstExp      = reg_dst;
  assign ExtendExp      = extend;
  assign PCtoRegExp     = pc_to_reg;
  assign ALUControlExp  = alu_ctrl;
  assign BranchExp      = branch;
  assign A3TempExp      = a3_tmp;
  assign A3Exp          = a3;
  assign RD1Exp         = rd1;
  assign RD2Exp         = rd2;
  assign SrcAExp        = src_a;
  assign SrcBExp        = src_b;
  assign ALUResultExp   = alu_res;
  assign DataMemReadExp = dmem_rd;
  assign WD3TempExp     = wd3_tmp;
  assign WD3Exp         = wd3;
  assign ZeroExp        = zero;

endmodule

// File: tb/tb_chip_instr_ip_cache02.sv
// Directed program run on chip_instr_ip_cache02; per-instruction expectations
// are queued up front and popped as each instruction is observed.
module tb_chip_instr_ip_cache02;

  function automatic logic [8191:0] mk_prog();
    logic [8191:0] p;
    p = '0;
    p[0*32 +: 32]  = 32'h20010005; // 0x000 addi $1,$0,5
    p[1*32 +: 32]  = 32'hAC010008; // 0x004 sw   $1,8($0)
    p[2*32 +: 32]  = 32'h8C020008; // 0x008 lw   $2,8($0)
    p[3*32 +: 32]  = 32'h20000007; // 0x00C addi $0,$0,7
    p[4*32 +: 32]  = 32'h10210002; // 0x010 beq  $1,$1,+2
    p[5*32 +: 32]  = 32'h20050001; // 0x014 skipped
    p[6*32 +: 32]  = 32'h20050002; // 0x018 skipped
    p[7*32 +: 32]  = 32'h00001820; // 0x01C add  $3,$0,$0
    p[8*32 +: 32]  = 32'h0C000040; // 0x020 jal  0x40
    p[64*32 +: 32] = 32'h14220005; // 0x100 bne  $1,$2,+5
    p[65*32 +: 32] = 32'h3C048000; // 0x104 lui  $4,0x8000
    p[66*32 +: 32] = 32'h00042903; // 0x108 sra  $5,$4,4
    p[67*32 +: 32] = 32'h3406FFFF; // 0x10C ori  $6,$0,0xFFFF
    p[68*32 +: 32] = 32'h00A0382A; // 0x110 slt  $7,$5,$0
    p[69*32 +: 32] = 32'h00A0402B; // 0x114 sltu $8,$5,$0
    p[70*32 +: 32] = 32'h00014822; // 0x118 sub  $9,$0,$1
    p[71*32 +: 32] = 32'hFC000000; // 0x11C unsupported opcode
    p[72*32 +: 32] = 32'h08000048; // 0x120 j    0x120
    return p;
  endfunction

  localparam logic [8191:0] PROG = mk_prog();

  logic        clk, rst;
  logic [31:0] instrExp, PCExp, IPCExp, ExtendImmExp;
  logic        MemtoRegExp, MemWriteExp, RegWriteExp, ALUSrcAExp, ALUSrcBExp;
  logic        RegDstExp, ExtendExp, PCtoRegExp, ZeroExp;
  logic [4:0]  ALUControlExp, A3TempExp, A3Exp;
  logic [1:0]  BranchExp;
  logic [31:0] RD1Exp, RD2Exp, SrcAExp, SrcBExp, ALUResultExp, DataMemReadExp, WD3TempExp, WD3Exp;

  chip_instr_ip_cache02 #(.ROM_INIT(PROG)) dut (
    .clk(clk), .rst(rst),
    .instrExp(instrExp), .PCExp(PCExp), .IPCExp(IPCExp), .ExtendImmExp(ExtendImmExp),
    .MemtoRegExp(MemtoRegExp), .MemWriteExp(MemWriteExp), .RegWriteExp(RegWriteExp),
    .ALUSrcAExp(ALUSrcAExp), .ALUSrcBExp(ALUSrcBExp), .RegDstExp(RegDstExp),
    .ExtendExp(ExtendExp), .PCtoRegExp(PCtoRegExp), .ALUControlExp(ALUControlExp),
    .BranchExp(BranchExp), .A3TempExp(A3TempExp), .A3Exp(A3Exp),
    .RD1Exp(RD1Exp), .RD2Exp(RD2Exp), .SrcAExp(SrcAExp), .SrcBExp(SrcBExp),
    .ALUResultExp(ALUResultExp), .DataMemReadExp(DataMemReadExp),
    .WD3TempExp(WD3TempExp), .WD3Exp(WD3Exp), .ZeroExp(ZeroExp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic        rw;
    logic        mw;
    logic [1:0]  br;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic push(input string tag, input logic [31:0] pc, input logic [31:0] alu,
                      input logic [4:0] a3, input logic [31:0] wd3,
                      input logic rw, input logic mw, input logic [1:0] br);
    exp_t e;
    e.tag = tag; e.pc = pc; e.alu = alu; e.a3 = a3; e.wd3 = wd3;
    e.rw = rw; e.mw = mw; e.br = br;
    q.push_back(e);
  endtask

  task automatic check_step();
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = q.pop_front();
      chk({e.tag, ".pc"},  PCExp,                e.pc);
      chk({e.tag, ".alu"}, ALUResultExp,         e.alu);
      chk({e.tag, ".a3"},  {27'd0, A3Exp},       {27'd0, e.a3});
      chk({e.tag, ".wd3"}, WD3Exp,               e.wd3);
      chk({e.tag, ".rw"},  {31'd0, RegWriteExp}, {31'd0, e.rw});
      chk({e.tag, ".mw"},  {31'd0, MemWriteExp}, {31'd0, e.mw});
      chk({e.tag, ".br"},  {30'd0, BranchExp},   {30'd0, e.br});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    push("addi",  32'h000, 32'd5,        5'd1,  32'd5,        1'b1, 1'b0, 2'b00);
    push("sw",    32'h004, 32'd8,        5'd1,  32'd8,        1'b0, 1'b1, 2'b00);
    push("lw",    32'h008, 32'd8,        5'd2,  32'd5,        1'b1, 1'b0, 2'b00);
    push("addi0", 32'h00C, 32'd7,        5'd0,  32'd7,        1'b1, 1'b0, 2'b00);
    push("beq",   32'h010, 32'd0,        5'd1,  32'd0,        1'b0, 1'b0, 2'b01);
    push("add",   32'h01C, 32'd0,        5'd3,  32'd0,        1'b1, 1'b0, 2'b00);
    push("jal",   32'h020, 32'd0,        5'd31, 32'h24,       1'b1, 1'b0, 2'b11);
    push("bne",   32'h100, 32'd0,        5'd2,  32'd0,        1'b0, 1'b0, 2'b10);
    push("lui",   32'h104, 32'h80000000, 5'd4,  32'h80000000, 1'b1, 1'b0, 2'b00);
    push("sra",   32'h108, 32'hF8000000, 5'd5,  32'hF8000000, 1'b1, 1'b0, 2'b00);
    push("ori",   32'h10C, 32'h0000FFFF, 5'd6,  32'h0000FFFF, 1'b1, 1'b0, 2'b00);
    push("slt",   32'h110, 32'd1,        5'd7,  32'd1,        1'b1, 1'b0, 2'b00);
    push("sltu",  32'h114, 32'd0,        5'd8,  32'd0,        1'b1, 1'b0, 2'b00);
    push("sub",   32'h118, 32'hFFFFFFFB, 5'd9,  32'hFFFFFFFB, 1'b1, 1'b0, 2'b00);
    push("nop",   32'h11C, 32'd0,        5'd0,  32'd0,        1'b0, 1'b0, 2'b00);
    push("j",     32'h120, 32'd0,        5'd0,  32'd0,        1'b0, 1'b0, 2'b11);
    push("j_loop",32'h120, 32'd0,        5'd0,  32'd0,        1'b0, 1'b0, 2'b11);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.pc",  PCExp,  32'h0);
    chk("rst.ipc", IPCExp, 32'h4);
    chk("rst.alu", ALUResultExp, 32'd5);
    chk("rst.rw",  {31'd0, RegWriteExp}, 32'd1);

    rst = 1'b0;
    #1;
    check_step(); chk("addi.srcb_sel", {31'd0, ALUSrcBExp}, 32'd1);           tick();
    check_step();                                                             tick();
    check_step(); chk("lw.dmem", DataMemReadExp, 32'd5);                       tick();
    check_step();                                                             tick();
    check_step(); chk("beq.zero", {31'd0, ZeroExp}, 32'd1);                    tick();
    check_step(); chk("add.rd1", RD1Exp, 32'd0);                               tick();
    check_step(); chk("jal.pctoreg", {31'd0, PCtoRegExp}, 32'd1);              tick();
    check_step(); chk("bne.zero", {31'd0, ZeroExp}, 32'd1);                    tick();
    check_step();                                                             tick();
    check_step(); chk("sra.srca", SrcAExp, 32'd4);                             tick();
    check_step(); chk("ori.ext", {31'd0, ExtendExp}, 32'd0);                   tick();
    check_step();                                                             tick();
    check_step();                                                             tick();
    check_step();                                                             tick();
    check_step();                                                             tick();
    check_step();                                                             tick();
    check_step();

    // Mid-program reset: PC must drop to 0 without waiting for a clock edge
    rst = 1'b1;
    #1;
    chk("midrst.pc",  PCExp,  32'h0);
    chk("midrst.ipc", IPCExp, 32'h4);
    chk("midrst.alu", ALUResultExp, 32'd5);
    tick();
    chk("midrst.hold_pc", PCExp, 32'h0);
    rst = 1'b0;
    push("re_addi", 32'h000, 32'd5, 5'd1, 32'd5, 1'b1, 1'b0, 2'b00);
    push("re_sw",   32'h004, 32'd8, 5'd1, 32'd8, 1'b0, 1'b1, 2'b00);
    #1;
    check_step(); tick();
    check_step(); chk("re_sw.rd2", RD2Exp, 32'd5);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
